// File: rtl/fc_buffer_reader.sv
// Streams the pooled FC input vector out of the per-batch FC data buffers,
// sweeping every buffer address FC_PASSES times under credit-based read issue.
module fc_buffer_reader #(
    parameter int AF         = 3,
    parameter int BATCH      = 9,
    parameter int DATA_WIDTH = 8,
    parameter int REAL_HOUT  = 7,
    parameter int LAST_N     = 512,
    parameter int FC_PASSES  = 4,
    parameter int RD_LAT     = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     buffer_reader_en,
    output logic                                     buffer_reader_done,
    output logic [BATCH-1:0]                         RAM_reader_rd_en,
    output logic [BATCH-1:0][ADDR_WIDTH-1:0]         RAM_reader_rd_ADDR,
    input  logic [BATCH-1:0][AF*DATA_WIDTH-1:0]      RAM_reader_rd_data,
    output logic [BATCH-1:0][AF-1:0][DATA_WIDTH-1:0] fc_data_out,
    output logic                                     fc_data_valid,
    input  logic                                     fc_data_ready,
    output logic                                     fc_data_last,
    output logic                                     fc_pass_last
);
    localparam int WORDS  = ((LAST_N + AF - 1) / AF) * REAL_HOUT * REAL_HOUT;
    localparam int FIFO_D = RD_LAT + 2;
    localparam int AW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW     = (FC_PASSES > 1) ? $clog2(FC_PASSES) : 1;
    localparam int PTRW   = $clog2(FIFO_D);
    localparam int CNTW   = $clog2(FIFO_D + 1);
    localparam int SW     = CNTW + 2;
    localparam int DW     = BATCH * AF * DATA_WIDTH;
    localparam int EW     = DW + 2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(FC_PASSES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [PW-1:0]          pass_q, pass_d;
    logic                   rd_en_q, rd_last_q, rd_plast_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic [RD_LAT-1:0][2:0] pipe_q;
    logic [EW-1:0]          mem_q [FIFO_D];
    logic [PTRW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]        count_q;
    logic [SW-1:0]          inflight;
    logic [EW-1:0]          head;
    logic                   fifo_valid, push, pop, credit_ok, issue;

    function automatic logic [PTRW-1:0] ptrInc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && fc_data_ready;
    assign push       = pipe_q[RD_LAT-1][2];
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        inflight = SW'(rd_en_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SW'(pipe_q[i][2]);
        end
    end

    // A beat leaving this cycle frees its slot in time for a read issued now.
    assign credit_ok = (SW'(count_q) + inflight) < (SW'(FIFO_D) + SW'(pop));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (buffer_reader_en) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                    pass_d  = '0;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        pass_d = pass_q + 1'b1;
                        if (pass_q == LAST_PASS) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0 && (count_q == '0 || (count_q == CNTW'(1) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_plast_q <= 1'b0;
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            rd_en_q <= issue;
            if (issue) begin
                rd_addr_q  <= ADDR_WIDTH'(addr_q);
                rd_last_q  <= (addr_q == LAST_ADDR);
                rd_plast_q <= (pass_q == LAST_PASS);
            end
            pipe_q[0] <= {rd_en_q, rd_last_q, rd_plast_q};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (push) wr_ptr_q <= ptrInc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptrInc(rd_ptr_q);
            count_q <= count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // Return data lands in the FIFO the cycle it appears on the RAM port.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pipe_q[RD_LAT-1][1:0], RAM_reader_rd_data};
    end

    assign RAM_reader_rd_en   = {BATCH{rd_en_q}};
    assign RAM_reader_rd_ADDR = {BATCH{rd_addr_q}};
    assign fc_data_valid      = fifo_valid;
    assign fc_data_last       = fifo_valid & head[DW+1];
    assign fc_pass_last       = fifo_valid & head[DW];
    assign fc_data_out        = fifo_valid ? head[DW-1:0] : '0;
    assign buffer_reader_done = (state_q == DONE);

endmodule
